// File: rtl/simon_if.sv
// Handshake bundle between the Simon round controller and the button/lamp front end.
interface simon_if #(
  parameter int LW = 5
);
  logic          start;
  logic [1:0]    rand_num;
  logic [1:0]    player_num;
  logic          player_pressed;
  logic          simon_turn;
  logic          show_valid;
  logic [1:0]    show_num;
  logic [LW-1:0] round_len;
  logic          game_over;
  logic          win;

  modport master (
    output start, rand_num, player_num, player_pressed,
    input  simon_turn, show_valid, show_num, round_len, game_over, win
  );

  modport slave (
    input  start, rand_num, player_num, player_pressed,
    output simon_turn, show_valid, show_num, round_len, game_over, win
  );
endinterface

// File: rtl/simon_sequencer.sv
// Simon round controller: stores the colour sequence, plays it back, checks presses.
// Optional player inactivity timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 300
) (
  input logic     clk,
  input logic     reset,
  simon_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ADD          = 3'd1;
  localparam logic [2:0] SHOW_OFF     = 3'd2;
  localparam logic [2:0] SHOW_ON      = 3'd3;
  localparam logic [2:0] WAIT_PRESS   = 3'd4;
  localparam logic [2:0] WAIT_RELEASE = 3'd5;
  localparam logic [2:0] OVER         = 3'd6;
  localparam logic [2:0] WIN          = 3'd7;

  localparam logic [15:0]   OFF_LAST = 16'(OFF_TICKS - 1);
  localparam logic [15:0]   ON_LAST  = 16'(ON_TICKS - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT_TICKS - 1);
`endif

  if (MAX_LEN < 1 || ON_TICKS < 1 || OFF_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_cfg_check
    $error("simon_sequencer: length and tick parameters must be at least 1");
  end

  logic [2:0]    state;
  logic [1:0]    mem [MAX_LEN];
  logic [LW-1:0] round_len;
  logic [LW-1:0] idx;
  logic [15:0]   tick;
  logic          prev_pressed;
  logic          rise;
  logic          last_idx;
  logic [1:0]    cur_num;

  assign rise     = bus.player_pressed & ~prev_pressed;
  assign last_idx = (idx == round_len - LW'(1));
  assign cur_num  = mem[idx[AW-1:0]];

  // Sequence storage is deliberately never cleared; only entries below round_len are read.
  always_ff @(posedge clk) begin
    if (state == ADD) mem[round_len[AW-1:0]] <= bus.rand_num;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      round_len    <= '0;
      idx          <= '0;
      tick         <= '0;
      prev_pressed <= 1'b0;
    end else begin
      prev_pressed <= bus.player_pressed;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= ADD;
            round_len <= '0;
          end
        end
        ADD: begin
          round_len <= round_len + LW'(1);
          idx       <= '0;
          tick      <= '0;
          state     <= SHOW_OFF;
        end
        SHOW_OFF: begin
          if (tick == OFF_LAST) begin
            tick  <= '0;
            state <= SHOW_ON;
          end else begin
            tick <= tick + 16'd1;
          end
        end
        SHOW_ON: begin
          if (tick == ON_LAST) begin
            tick <= '0;
            if (last_idx) begin
              idx   <= '0;
              state <= WAIT_PRESS;
            end else begin
              idx   <= idx + LW'(1);
              state <= SHOW_OFF;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end
        WAIT_PRESS: begin
          // A button held over from playback has prev_pressed set, so it never rises here.
          if (rise) begin
            tick  <= '0;
            state <= (bus.player_num == cur_num) ? WAIT_RELEASE : OVER;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (tick == TO_LAST) begin
            state <= OVER;
          end else begin
            tick <= tick + 16'd1;
          end
`endif
        end
        WAIT_RELEASE: begin
          if (!bus.player_pressed) begin
            if (last_idx) begin
              state <= (round_len == LEN_MAX) ? WIN : ADD;
            end else begin
              idx   <= idx + LW'(1);
              tick  <= '0;
              state <= WAIT_PRESS;
            end
          end
        end
        OVER, WIN: begin
          if (bus.start) begin
            state     <= ADD;
            round_len <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.simon_turn = (state == ADD) || (state == SHOW_OFF) || (state == SHOW_ON);
  assign bus.show_valid = (state == SHOW_ON);
  assign bus.show_num   = (state == SHOW_ON) ? cur_num : 2'b00;
  assign bus.round_len  = round_len;
  assign bus.game_over  = (state == OVER);
  assign bus.win        = (state == WIN);
endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer; playback lamps are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_simon_sequencer;
  localparam int MAX_LEN       = 2;
  localparam int ON_TICKS      = 3;
  localparam int OFF_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 10;
  localparam int LW            = $clog2(MAX_LEN + 1);

  typedef struct {
    logic [1:0] colour;
    int         gap;
  } lamp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  lamp_t exp_q[$];

  simon_if #(.LW(LW)) bus ();

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    bus.player_num     = c;
    bus.player_pressed = 1'b1;
    step(1);
  endtask

  task automatic release_btn();
    bus.player_pressed = 1'b0;
    step(1);
  endtask

  task automatic wait_playback(input string tag);
    for (int i = 0; i < 200 && bus.simon_turn; i++) step(1);
    check({tag, "_done"}, bus.simon_turn, 0);
    check({tag, "_lamps"}, exp_q.size(), 0);
  endtask

  // Lamp monitor: each rising show_valid pops one expected colour and dark-gap length.
  initial begin
    lamp_t cur;
    logic  prev_sv;
    logic  have;
    int    on_cnt;
    int    dark_cnt;
    cur = '{2'd0, 0};
    prev_sv = 1'b0; have = 1'b0; on_cnt = 0; dark_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_sv = 1'b0; have = 1'b0; on_cnt = 0; dark_cnt = 0;
      end else begin
        if (bus.show_valid) begin
          if (!prev_sv) begin
            on_cnt = 0;
            if (exp_q.size() == 0) begin
              have = 1'b0;
              check("show_unexpected", bus.show_valid, 0);
            end else begin
              cur  = exp_q.pop_front();
              have = 1'b1;
              check("show_gap", dark_cnt, cur.gap);
            end
          end
          if (have) check("show_num", bus.show_num, cur.colour);
          on_cnt++;
          dark_cnt = 0;
        end else begin
          if (prev_sv) check("show_on_len", on_cnt, ON_TICKS);
          dark_cnt = bus.simon_turn ? dark_cnt + 1 : 0;
        end
        prev_sv = bus.show_valid;
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.rand_num = 2'd0; bus.player_num = 2'd0; bus.player_pressed = 1'b0;
    step(1);
    check("rst_turn", bus.simon_turn, 0);
    check("rst_show_valid", bus.show_valid, 0);
    check("rst_show_num", bus.show_num, 0);
    check("rst_len", bus.round_len, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_win", bus.win, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Round 1 of a full game ending in a win
    bus.rand_num = 2'd2;
    exp_q.push_back('{2'd2, OFF_TICKS + 1});
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("start_add_turn", bus.simon_turn, 1);
    check("start_add_len", bus.round_len, 0);
    step(1);
    check("add_len", bus.round_len, 1);
    check("add_dark", bus.show_valid, 0);
    wait_playback("r1_play");
    press(2'd2);
    check("r1_press_ok", bus.game_over, 0);
    bus.rand_num = 2'd1;
    exp_q.push_back('{2'd2, OFF_TICKS + 1});
    exp_q.push_back('{2'd1, OFF_TICKS});
    release_btn();
    check("r1_rel_turn", bus.simon_turn, 1);
    check("r1_rel_len", bus.round_len, 1);
    step(1);
    check("r2_len", bus.round_len, 2);
    wait_playback("r2_play");
    press(2'd2);
    release_btn();
    check("r2_mid_turn", bus.simon_turn, 0);
    check("r2_mid_win", bus.win, 0);
    press(2'd1);
    release_btn();
    check("win", bus.win, 1);
    check("win_len", bus.round_len, 2);
    check("win_turn", bus.simon_turn, 0);
    step(3);
    check("win_hold", bus.win, 1);

    // Start beats simultaneous button activity in WIN
    bus.rand_num = 2'd2;
    exp_q.push_back('{2'd2, OFF_TICKS + 1});
    bus.start = 1'b1; bus.player_pressed = 1'b1; bus.player_num = 2'd0;
    step(1);
    bus.start = 1'b0; bus.player_pressed = 1'b0;
    check("win_start_turn", bus.simon_turn, 1);
    check("win_start_win", bus.win, 0);
    check("win_start_len", bus.round_len, 0);
    step(1);
    check("win_start_len1", bus.round_len, 1);
    wait_playback("w_play");
    check("pre_wrong_over", bus.game_over, 0);
    press(2'd3);
    check("wrong_over", bus.game_over, 1);
    release_btn();
    step(5);
    check("over_hold", bus.game_over, 1);
    check("over_turn", bus.simon_turn, 0);

    // Restart from OVER; button held across the end of playback must not count
    bus.rand_num = 2'd2;
    exp_q.push_back('{2'd2, OFF_TICKS + 1});
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    check("restart_len", bus.round_len, 1);
    check("restart_over", bus.game_over, 0);
    step(3);
    bus.player_num = 2'd3; bus.player_pressed = 1'b1;
    wait_playback("h_play");
    step(4);
    check("held_over", bus.game_over, 0);
    check("held_turn", bus.simon_turn, 0);
    check("held_len", bus.round_len, 1);
    release_btn();
    bus.rand_num = 2'd3;
    exp_q.push_back('{2'd2, OFF_TICKS + 1});
    exp_q.push_back('{2'd3, OFF_TICKS});
    press(2'd2);
    check("held_press_over", bus.game_over, 0);
    release_btn();
    check("held_adv_turn", bus.simon_turn, 1);
    step(1);
    check("held_adv_len", bus.round_len, 2);

    // Asynchronous reset in the middle of a lamp
    for (int i = 0; i < 50 && !bus.show_valid; i++) step(1);
    check("rst_lamp_seen", bus.show_valid, 1);
    step(1);
    #2 reset = 1'b1;
    #1;
    check("arst_show_valid", bus.show_valid, 0);
    check("arst_turn", bus.simon_turn, 0);
    check("arst_len", bus.round_len, 0);
    step(2);
    reset = 1'b0;
    step(5);
    check("idle_turn", bus.simon_turn, 0);
    check("idle_len", bus.round_len, 0);

    // Player inactivity in WAIT_PRESS
    bus.rand_num = 2'd1;
    exp_q.push_back('{2'd1, OFF_TICKS + 1});
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_playback("t_play");
`ifdef SIMON_TIMEOUT_EN
    step(TIMEOUT_TICKS - 1);
    check("to_before", bus.game_over, 0);
    step(1);
    check("to_over", bus.game_over, 1);
`else
    step(1000);
    check("no_to_over", bus.game_over, 0);
    check("no_to_turn", bus.simon_turn, 0);
    check("no_to_len", bus.round_len, 1);
    press(2'd1);
    release_btn();
    check("late_press_turn", bus.simon_turn, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
